// File: rtl/multicycle_subtractor_pkg.sv
// Shared definitions for the multicycle subtractor: FSM state encodings,
// default widths and parameter-legality helpers.
package multicycle_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 64;
  localparam int unsigned DefaultChunk = 16;

  // Number of slices (cycles) one operation takes.
  function automatic int unsigned slice_count(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  // WIDTH must split into whole CHUNK-bit slices.
  function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtract with borrow-in and borrow-out.
// bout is the sign of the (CHUNK+1)-bit result, i.e. 1 when a < b + bin.
module chunk_subtractor #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  // Zero-extend by one bit so the borrow lands in the top bit.
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};

endmodule

// File: rtl/multicycle_subtractor.sv
// Multicycle subtractor: D = A - B - Bin over WIDTH bits, one CHUNK-bit slice
// per clock, LSB slice first, with valid/ready handshakes on both sides.
// Optional feature macro: MULTICYCLE_SUB_SIGNED_OVF_EN adds a signed-overflow
// output ovf, registered with Bout on the final slice.
module multicycle_subtractor
  import multicycle_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = slice_count(WIDTH, CHUNK);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
    $fatal(1, "multicycle_subtractor: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic [IdxW-1:0]   idx_q, idx_d;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  int unsigned       slice_base;
  logic [CHUNK-1:0]  a_slice, b_slice, diff;
  logic              slice_bout;

  // One shared slice subtractor; the index picks which slice it works on.
  assign slice_base = 32'(idx_q) * CHUNK;
  assign a_slice    = a_q[slice_base +: CHUNK];
  assign b_slice    = b_q[slice_base +: CHUNK];

  chunk_subtractor #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (borrow_q),
    .diff (diff),
    .bout (slice_bout)
  );

  // Next-state logic: capture in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    idx_d    = idx_q;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        d_d[slice_base +: CHUNK] = diff;
        borrow_d = slice_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          bout_d  = slice_bout;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
          // Operand signs differ and the result sign differs from A's.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[CHUNK-1] != a_q[WIDTH-1]);
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      idx_q    <= '0;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      idx_q    <= idx_d;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign D         = d_q;
  assign Bout      = bout_q;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Self-checking bench for multicycle_subtractor (WIDTH=64, CHUNK=16).
// Inputs change 1 time unit after the rising edge; the scoreboard monitor
// samples on the falling edge.
module tb_multicycle_subtractor;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CHUNK = 16;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_subtractor #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout)
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a full-width subtraction with one extra bit for the borrow.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    logic [WIDTH:0] r;
    exp_t           m;
    r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    m.d    = r[WIDTH-1:0];
    m.bout = r[WIDTH];
    m.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Present one operation for exactly one accepting edge, then scramble inputs.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Bin      = bin;
    sb.push_back(model(a, b, bin));
    step();
    in_valid = 1'b0;
    A        = rnd64();
    B        = rnd64();
    Bin      = 1'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid rises (bounded).
  task automatic wait_valid(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < int'(4 * N + 8)) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input string tag);
    out_ready = 1'b1;
    send(a, b, bin);
    wait_valid(tag);
    step();
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Scoreboard: compare on the cycle before each output handshake edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("D", D, e.d);
        check("Bout", 64'(Bout), 64'(e.bout));
`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
        check("ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [WIDTH-1:0] ra, rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_D", D, 64'd0);
    check("rst_Bout", 64'(Bout), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed cases.
    run_op(64'd5, 64'd3, 1'b0, "small");
    run_op(64'd0, 64'd1, 1'b0, "ripple_all");
    run_op(64'h0000_0000_0001_0000, 64'd0, 1'b1, "slice_cross");
    run_op(64'd123, 64'd123, 1'b1, "equal_bin");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "all_ones");

    // Back-pressure: result must hold while out_ready is low; in_valid ignored.
    out_ready = 1'b0;
    ra = 64'hDEAD_BEEF_0000_1234;
    rb = 64'h1111_2222_3333_4444;
    e  = model(ra, rb, 1'b1);
    send(ra, rb, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_D_stable", D, e.d);
      check("bp_Bout_stable", 64'(Bout), 64'(e.bout));
      in_valid = (i == 1);
      A        = 64'd7;
      B        = 64'd1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    repeat (6) step();
    check("bp_ignored_no_op", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during RUN abandons the operation.
    send(64'd100, 64'd50, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_D", D, 64'd0);
    check("midrst_Bout", 64'(Bout), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    run_op(64'd9, 64'd4, 1'b0, "post_rst");

`ifdef MULTICYCLE_SUB_SIGNED_OVF_EN
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, "ovf_neg");
    run_op(64'd7, 64'd7, 1'b0, "ovf_zero");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "ovf_pos");
`endif

    // Random operations with random output stalls.
    for (int k = 0; k < 12; k++) begin
      ra = (k == 0) ? 64'd0 : rnd64();
      rb = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
      out_ready = 1'b0;
      send(ra, rb, 1'($urandom));
      wait_valid("rnd");
      repeat ($urandom_range(0, 3)) step();
      out_ready = 1'b1;
      step();
      check("rnd_valid_drop", 64'(out_valid), 64'd0);
    end

    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_subtractor.md
Name: multicycle_subtractor

Overview:
- Computes D = A - B - Bin over WIDTH bits as a borrow chain, one CHUNK-bit slice per clock, LSB slice first.
- Complements the team's ripple-carry adder chain.
- Serves datapath stages that trade latency for a short combinational path.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- WIDTH, 64, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 16, bits subtracted per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  A, B and Bin are valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  D and Bout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- D  output  WIDTH  difference register.
- Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, D=0, Bout=0, out_valid=0, slice index=0, internal operands=0. in_ready=1, since it is decoded directly from state==IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: capture A, B and Bin, clear index, go to RUN.
  - RUN: in_ready=0. Each cycle computes slice idx: {b, D[idx]} = A[idx] - B[idx] - borrow. Borrow starts at the captured Bin and the slice's borrow-out becomes the next slice's borrow. Increment idx. On the slice where idx==N-1: register Bout, go to DONE.
  - DONE: out_valid=1. D and Bout stay stable. in_ready=0. On out_ready: out_valid drops on the next edge and the block returns to IDLE.
- Latency: out_valid rises exactly N cycles after the accepting edge (4 at default parameters). If out_ready is already high, the output handshake completes on the following edge. Throughput is one operation per N+2 cycles.
- D is written slice by slice while in RUN. It is only meaningful while out_valid=1; the bench checks D and Bout only there.
- in_valid while not in IDLE: ignored, no capture, no error. Inputs are sampled only on the accepting edge; later changes to A, B and Bin have no effect.
- out_ready while out_valid=0: ignored.
- No same-cycle accept and retire: DONE→IDLE costs one cycle before the next accept.
- CHUNK==WIDTH: N=1, single RUN cycle, same protocol.
- Wrap-around: the result is modulo 2^WIDTH. Borrow leaving the MSB slice appears only on Bout.
- Reset asserted mid-operation: the operation is abandoned with no partial result or out_valid. After release the block is in IDLE with outputs at reset values.

Optional Feature:
- Macro: MULTICYCLE_SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered alongside Bout in the final RUN slice. ovf=1 iff two's-complement signed overflow: A[MSB] != B[MSB] and D[MSB] != A[MSB]. ovf is held with D while out_valid=1.
- Undefined: no ovf port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Shared header/package holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default WIDTH and CHUNK.
  - a parameter check: WIDTH % CHUNK != 0 is a fatal elaboration error.
- One natural sub-module, chunk_subtractor: combinational CHUNK-bit subtract with borrow-in and borrow-out, instantiated once and reused every RUN cycle. The top holds the FSM, operand registers and index counter.

Test Plan (WIDTH=64, CHUNK=16):
- A=5, B=3, Bin=0, out_ready=1 → out_valid 4 cycles after accept; D=2, Bout=0.
- A=0, B=1, Bin=0 → D=0xFFFF_FFFF_FFFF_FFFF, Bout=1 (borrow ripples through all 4 slices).
- A=0x0000_0000_0001_0000, B=0, Bin=1 → D=0x0000_0000_0000_FFFF, Bout=0 (borrow crosses the slice boundary only).
- Back-pressure: out_ready held low 5 cycles after out_valid → D/Bout stable, in_ready=0, a second in_valid pulse is ignored. out_ready=1 → out_valid low next edge, in_ready=1 the following cycle.
- Reset pulsed after 2 RUN cycles → D=0, Bout=0, out_valid=0 immediately; in_ready=1. A new A=9, B=4 after release → D=5.
- With MULTICYCLE_SUB_SIGNED_OVF_EN: A=0x8000_0000_0000_0000, B=1 → D=0x7FFF_FFFF_FFFF_FFFF, ovf=1, Bout=0. Then A=B=7 → D=0, ovf=0.
